// File: rtl/div_fp32_iter.sv
// div_fp32_iter: iterative fp32 divider (truncating, denormals flushed), valid/ready handshake on both sides
module div_fp32_iter #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_dbz
);
    localparam int N_ITER = 25 / BPC;
    localparam int CW = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t            state, state_nx;
    special_t          special, special_in;
    logic [25:0]       rem, rem_nx;
    logic [26:0]       trial;
    logic [23:0]       dvs;
    logic [24:0]       quo, quo_nx;
    logic [CW-1:0]     cnt;
    logic              sign, dbz, dbz_in;
    logic              in_ready_nx, out_valid_nx;
    logic signed [9:0] ediff, e_res;
    logic [22:0]       sig;
    logic [31:0]       res;

    logic [7:0] ea, eb;
    logic a_zero, a_inf, a_nan, a_fin, b_zero, b_inf, b_nan, b_fin;
    logic is_nan, is_inf, is_zero;

    assign ea     = in_a[30:23];
    assign eb     = in_b[30:23];
    assign a_zero = ea == 8'h00;
    assign b_zero = eb == 8'h00;
    assign a_fin  = ea != 8'hFF;
    assign b_fin  = eb != 8'hFF;
    assign a_inf  = !a_fin && in_a[22:0] == 23'h0;
    assign b_inf  = !b_fin && in_b[22:0] == 23'h0;
    assign a_nan  = !a_fin && in_a[22:0] != 23'h0;
    assign b_nan  = !b_fin && in_b[22:0] != 23'h0;

    // Classify the incoming operand pair so the special result is known before the divide starts
    always_comb begin
        is_nan     = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        dbz_in     = a_fin && !a_zero && b_zero;
        is_inf     = (a_inf && b_fin) || dbz_in;
        is_zero    = (a_zero && !b_zero && !b_nan) || (a_fin && b_inf);
        special_in = is_nan ? SP_NAN : is_inf ? SP_INF : is_zero ? SP_ZERO : SP_NONE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: the DIV phase lasts exactly N_ITER edges regardless of operand class
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = in_valid ? DIV : IDLE;
            DIV:     state_nx = (cnt == CW'(N_ITER - 1)) ? NORM : DIV;
            NORM:    state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flags are registered alongside the state
    always_comb begin
        in_ready_nx  = state_nx == IDLE;
        out_valid_nx = state_nx == DONE;
    end

    // Handshake output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Restoring division step: BPC trial subtractions per edge, shifting quotient bits in at the bottom
    always_comb begin
        rem_nx = rem;
        quo_nx = quo;
        trial  = '0;
        for (int i = 0; i < BPC; i++) begin
            trial  = {1'b0, rem_nx} - {3'b000, dvs};
            quo_nx = {quo_nx[23:0], ~trial[26]};
            rem_nx = (trial[26] ? rem_nx : trial[25:0]) << 1;
        end
    end

    // Normalise the 25-bit quotient and apply specials, then overflow/underflow, in priority order
    always_comb begin
        e_res = ediff + (quo[24] ? 10'sd127 : 10'sd126);
        sig   = quo[24] ? quo[23:1] : quo[22:0];
        res   = special == SP_NAN  ? {sign, 8'hFF, 23'h1} :
                special == SP_INF  ? {sign, 8'hFF, 23'h0} :
                special == SP_ZERO ? {sign, 31'h0} :
                e_res >= 10'sd255  ? {sign, 8'hFF, 23'h0} :
                e_res <= 10'sd0    ? {sign, 31'h0} :
                                     {sign, e_res[7:0], sig};
    end

    // Datapath: latch operands on accept, iterate in DIV, register the result in NORM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= 32'h0;
            out_dbz  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                rem     <= {2'b01, in_a[22:0]};
                dvs     <= {1'b1, in_b[22:0]};
                quo     <= '0;
                cnt     <= '0;
                sign    <= in_a[31] ^ in_b[31];
                ediff   <= {2'b00, ea} - {2'b00, eb};
                special <= special_in;
                dbz     <= dbz_in;
            end
            if (state == DIV) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt + CW'(1);
            end
            if (state == NORM) begin
                out_data <= res;
                out_dbz  <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_div_fp32_iter.sv
// tb_div_fp32_iter: randomized and directed checks of div_fp32_iter (BPC=1 and BPC=5) against a reference model
module tb_div_fp32_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = 32'h0;
    logic [31:0] in_b = 32'h0;
    logic        in_ready, out_valid, out_dbz;
    logic        in_ready5, out_valid5, out_dbz5;
    logic [31:0] out_data, out_data5;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    div_fp32_iter #(.BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dbz(out_dbz)
    );

    div_fp32_iter #(.BPC(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid5), .out_ready(out_ready),
        .out_data(out_data5), .out_dbz(out_dbz5)
    );

    // Reference: {dbz, result} from the number-model rules using plain integer arithmetic
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea, eb;
        bit az, ai, an, bz, bi, bn;
        logic s;
        longint unsigned num, den, q;
        int e;
        logic [22:0] sig;
        logic [31:0] ev;
        ea = a[30:23];
        eb = b[30:23];
        az = ea == 0;
        bz = eb == 0;
        ai = ea == 255 && a[22:0] == 0;
        bi = eb == 255 && b[22:0] == 0;
        an = ea == 255 && a[22:0] != 0;
        bn = eb == 255 && b[22:0] != 0;
        s = a[31] ^ b[31];
        if (an || bn || (az && bz) || (ai && bi)) return {1'b0, s, 8'hFF, 23'h1};
        if (ai) return {1'b0, s, 8'hFF, 23'h0};
        if (bz) return {1'b1, s, 8'hFF, 23'h0};
        if (az || bi) return {1'b0, s, 31'h0};
        num = (64'(a[22:0]) + 64'h800000) << 24;
        den = 64'(b[22:0]) + 64'h800000;
        q = num / den;
        if (q >= 64'h1000000) begin
            e = int'(ea) - int'(eb) + 127;
            sig = 23'((q >> 1) & 64'h7FFFFF);
        end else begin
            e = int'(ea) - int'(eb) + 126;
            sig = 23'(q & 64'h7FFFFF);
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        ev = e;
        return {1'b0, s, ev[7:0], sig};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned r;
        logic [7:0] e;
        logic [22:0] m;
        r = $urandom_range(0, 99);
        e = r < 10 ? 8'h00 : r < 20 ? 8'hFF : 8'($urandom_range(1, 254));
        m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Offer one operand pair to both dividers, collect latency/result of each, then release them together
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat1, output int lat5,
                          output logic [31:0] d1, output logic [31:0] d5,
                          output logic z1, output logic z5);
        lat1 = -1; lat5 = -1; d1 = 32'h0; d5 = 32'h0; z1 = 1'b0; z5 = 1'b0;
        for (int c = 0; c < 100 && !(in_ready && in_ready5); c++) begin
            @(posedge clk); #1;
        end
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (out_valid5 && lat5 < 0) begin lat5 = c; d5 = out_data5; z5 = out_dbz5; end
            if (out_valid && lat1 < 0) begin lat1 = c; d1 = out_data; z1 = out_dbz; end
            if (lat1 >= 0 && lat5 >= 0) break;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 8;
        if (in_ready !== 1'b1)     begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_data !== 32'h0)    begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        if (out_dbz !== 1'b0)      begin n_bad++; $display("FAIL reset_out_dbz: got %b want 0", out_dbz); end
        if (in_ready5 !== 1'b1)    begin n_bad++; $display("FAIL reset_in_ready5: got %b want 1", in_ready5); end
        if (out_valid5 !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid5: got %b want 0", out_valid5); end
        if (out_data5 !== 32'h0)   begin n_bad++; $display("FAIL reset_out_data5: got %h want 0", out_data5); end
        if (out_dbz5 !== 1'b0)     begin n_bad++; $display("FAIL reset_out_dbz5: got %b want 0", out_dbz5); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [10] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hBF800000,
                                 32'h7F000000, 32'h00800000, 32'h7FC00000, 32'hFF800000, 32'h7F800000};
        logic [31:0] tb [10] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000,
                                 32'h00800000, 32'h7F000000, 32'h3F800000, 32'h3F800000, 32'h00000000};
        logic [31:0] tq [10] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'h7F800001, 32'h80000000,
                                 32'h7F800000, 32'h00000000, 32'h7F800001, 32'hFF800000, 32'h7F800000};
        logic        tz [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int l1, l5;
        logic [31:0] d1, d5;
        logic z1, z5;
        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tb[i], l1, l5, d1, d5, z1, z5);
            n_cmp += 6;
            if (d1 !== tq[i]) begin n_bad++; $display("FAIL dir%0d_data %h/%h: got %h want %h", i, ta[i], tb[i], d1, tq[i]); end
            if (z1 !== tz[i]) begin n_bad++; $display("FAIL dir%0d_dbz: got %b want %b", i, z1, tz[i]); end
            if (l1 !== 26)    begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 26", i, l1); end
            if (d5 !== tq[i]) begin n_bad++; $display("FAIL dir%0d_data_bpc5 %h/%h: got %h want %h", i, ta[i], tb[i], d5, tq[i]); end
            if (z5 !== tz[i]) begin n_bad++; $display("FAIL dir%0d_dbz_bpc5: got %b want %b", i, z5, tz[i]); end
            if (l5 !== 6)     begin n_bad++; $display("FAIL dir%0d_latency_bpc5: got %0d want 6", i, l5); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [32:0] m;
        int l1, l5;
        logic [31:0] d1, d5;
        logic z1, z5;
        for (int i = 0; i < 60; i++) begin
            a = rand_fp();
            b = rand_fp();
            m = model(a, b);
            run_op(a, b, l1, l5, d1, d5, z1, z5);
            n_cmp += 6;
            if (d1 !== m[31:0]) begin n_bad++; $display("FAIL rnd_data %h/%h: got %h want %h", a, b, d1, m[31:0]); end
            if (z1 !== m[32])   begin n_bad++; $display("FAIL rnd_dbz %h/%h: got %b want %b", a, b, z1, m[32]); end
            if (l1 !== 26)      begin n_bad++; $display("FAIL rnd_latency: got %0d want 26", l1); end
            if (d5 !== m[31:0]) begin n_bad++; $display("FAIL rnd_data_bpc5 %h/%h: got %h want %h", a, b, d5, m[31:0]); end
            if (z5 !== m[32])   begin n_bad++; $display("FAIL rnd_dbz_bpc5 %h/%h: got %b want %b", a, b, z5, m[32]); end
            if (l5 !== 6)       begin n_bad++; $display("FAIL rnd_latency_bpc5: got %0d want 6", l5); end
        end
    endtask

    task automatic test_backpressure();
        int seen = 0;
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 60 && !out_valid; c++) begin @(posedge clk); #1; end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout: got %b want 1", out_valid); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40400000;
            @(posedge clk); #1;
            n_cmp += 3;
            if (out_data !== 32'h40400000) begin n_bad++; $display("FAIL bp_data_stable: got %h want 40400000", out_data); end
            if (in_ready !== 1'b0)         begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            if (out_valid !== 1'b1)        begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp += 2;
        if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL bp_offer_taken: got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int gap = -1;
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin gap = c; break; end
        end
        in_valid = 1'b0;
        n_cmp += 2;
        if (gap !== 28)                begin n_bad++; $display("FAIL b2b_period: got %0d want 28", gap); end
        if (out_data !== 32'h40400000) begin n_bad++; $display("FAIL b2b_data: got %h want 40400000", out_data); end
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp += 2;
        if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
        if (in_ready5 !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_bpc5: got %b want 1", in_ready5); end
    endtask

    task automatic test_reset_midop();
        int stale = 0;
        int l1, l5;
        logic [31:0] d1, d5;
        logic z1, z5;
        in_a = 32'h3F800000; in_b = 32'h00000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp += 6;
        if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (out_data !== 32'h0)  begin n_bad++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        if (out_valid5 !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid5: got %b want 0", out_valid5); end
        if (out_data5 !== 32'h0) begin n_bad++; $display("FAIL mid_out_data5: got %h want 0", out_data5); end
        if (out_dbz5 !== 1'b0)   begin n_bad++; $display("FAIL mid_out_dbz5: got %b want 0", out_dbz5); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid || out_valid5) stale++;
        end
        n_cmp++;
        if (stale !== 0) begin n_bad++; $display("FAIL mid_stale_result: got %0d valid cycles want 0", stale); end
        run_op(32'h40C00000, 32'h40000000, l1, l5, d1, d5, z1, z5);
        n_cmp += 3;
        if (d1 !== 32'h40400000) begin n_bad++; $display("FAIL mid_next_data: got %h want 40400000", d1); end
        if (l1 !== 26)           begin n_bad++; $display("FAIL mid_next_latency: got %0d want 26", l1); end
        if (d5 !== 32'h40400000) begin n_bad++; $display("FAIL mid_next_data_bpc5: got %h want 40400000", d5); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
